// File: rtl/lc3b_types.sv
// Shared types for the eviction write-back buffer control: FSM states, pLRU state
// and a line-index decoder used to build the per-line write enables.
package lc3b_types;

    localparam int EWB_LINES = 4;

    typedef logic [2:0] lc3b_ewb_plru;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WB,
        RD_MISS,
        DRAIN
    } ewb_state_t;

    function automatic logic [EWB_LINES-1:0] line_sel(input logic [1:0] idx);
        line_sel = '0;
        line_sel[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ewb_plru_update.sv
// Tree pLRU next-state for the 4-line buffer: bit2 picks the LRU pair,
// bit1 the LRU line within {0,1}, bit0 the LRU line within {2,3}.
module ewb_plru_update (
    input  logic [2:0] lru_out,
    input  logic [1:0] access_line,
    output logic [2:0] lru_in
);

    // The root bit is rewritten by every access, so its old value never matters.
    logic unused_root;
    assign unused_root = lru_out[2];

    always_comb begin
        case (access_line)
            2'd0:    lru_in = {2'b11, lru_out[0]};
            2'd1:    lru_in = {2'b10, lru_out[0]};
            2'd2:    lru_in = {1'b0, lru_out[1], 1'b1};
            default: lru_in = {1'b0, lru_out[1], 1'b0};
        endcase
    end

endmodule

// File: rtl/eviction_wb_control.sv
// Sequencing FSM for the 4-entry eviction write-back buffer between L2 and pmem.
// Optional background drain of dirty lines after a run of idle cycles: EWB_IDLE_DRAIN_EN.
module eviction_wb_control
`ifdef EWB_IDLE_DRAIN_EN
#(
    parameter int unsigned DRAIN_IDLE_CYCLES = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic       hit,
    input  logic [1:0] cline_and,
    input  logic [1:0] line,
    input  logic [1:0] ow_line,
    input  logic [3:0] valid_out,
    input  logic [3:0] dirty_out,
    input  logic [2:0] lru_out,
    output logic [3:0] valid_write,
    output logic       valid_in,
    output logic [3:0] dirty_write,
    output logic       dirty_in,
    output logic [3:0] tag_write,
    output logic [3:0] data_write,
    output logic       lru_write,
    output logic [2:0] lru_in,
    output logic       pmem_addr_sig,
    output logic       out_data_sel
);

    import lc3b_types::*;

    ewb_state_t   state, next_state;
    logic         full;
    logic [1:0]   plru_line;
    logic         lru_touch;
    logic         lru_clear;
    lc3b_ewb_plru plru_next;
    logic         drain_go;

    assign full = &(valid_out & dirty_out);

    ewb_plru_update u_plru (
        .lru_out     (lru_out),
        .access_line (plru_line),
        .lru_in      (plru_next)
    );

    assign lru_write = lru_touch | lru_clear;
    assign lru_in    = lru_touch ? plru_next : 3'b000;

`ifdef EWB_IDLE_DRAIN_EN
    localparam int CNT_W = $clog2(DRAIN_IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_IDLE_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_tick;

    assign idle_tick = (state == IDLE) && !mem_read && !mem_write && (|(valid_out & dirty_out));
    assign drain_go  = idle_tick && (idle_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || !idle_tick) begin
            idle_cnt <= '0;
        end else if (!drain_go) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign drain_go = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        valid_write   = '0;
        valid_in      = 1'b0;
        dirty_write   = '0;
        dirty_in      = 1'b0;
        tag_write     = '0;
        data_write    = '0;
        lru_touch     = 1'b0;
        lru_clear     = 1'b0;
        plru_line     = 2'd0;
        pmem_addr_sig = 1'b0;
        out_data_sel  = 1'b0;

        if (!rst) begin
            case (state)
                // NOTE: the line arrays carry no reset; INIT clears valid/dirty/pLRU through their write ports.
                INIT: begin
                    valid_write = '1;
                    dirty_write = '1;
                    lru_clear   = 1'b1;
                    next_state  = IDLE;
                end
                IDLE: begin
                    if (mem_write) begin
                        if (hit) begin
                            data_write  = line_sel(cline_and);
                            dirty_write = line_sel(cline_and);
                            dirty_in    = 1'b1;
                            plru_line   = cline_and;
                            lru_touch   = 1'b1;
                            mem_resp    = 1'b1;
                        end else if (!full) begin
                            tag_write   = line_sel(ow_line);
                            data_write  = line_sel(ow_line);
                            valid_write = line_sel(ow_line);
                            dirty_write = line_sel(ow_line);
                            valid_in    = 1'b1;
                            dirty_in    = 1'b1;
                            plru_line   = ow_line;
                            lru_touch   = 1'b1;
                            mem_resp    = 1'b1;
                        end else begin
                            next_state = WB;
                        end
                    end else if (mem_read) begin
                        if (hit) begin
                            plru_line = cline_and;
                            lru_touch = 1'b1;
                            mem_resp  = 1'b1;
                        end else begin
                            next_state = RD_MISS;
                        end
                    end else if (drain_go) begin
                        next_state = DRAIN;
                    end
                end
                // A forced write-back and a background drain move the same victim line.
                WB, DRAIN: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sig = 1'b1;
                    if (pmem_resp) begin
                        dirty_write = line_sel(line);
                        next_state  = IDLE;
                    end
                end
                RD_MISS: begin
                    pmem_read    = 1'b1;
                    out_data_sel = 1'b1;
                    if (pmem_resp) begin
                        mem_resp   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_eviction_wb_control.sv
// Self-checking bench for eviction_wb_control with a behavioural datapath/pmem model
// and a response scoreboard; the drain scenario runs only with EWB_IDLE_DRAIN_EN.
module tb_eviction_wb_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write, mem_resp;
    logic       pmem_read, pmem_write, pmem_resp;
    logic       hit;
    logic [1:0] cline_and, line, ow_line;
    logic [3:0] valid_out, dirty_out;
    logic [2:0] lru_out;
    logic [3:0] valid_write, dirty_write, tag_write, data_write;
    logic       valid_in, dirty_in, lru_write;
    logic [2:0] lru_in;
    logic       pmem_addr_sig, out_data_sel;

    always #5 clk = ~clk;

    eviction_wb_control dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .cline_and(cline_and), .line(line), .ow_line(ow_line),
        .valid_out(valid_out), .dirty_out(dirty_out), .lru_out(lru_out),
        .valid_write(valid_write), .valid_in(valid_in), .dirty_write(dirty_write), .dirty_in(dirty_in),
        .tag_write(tag_write), .data_write(data_write), .lru_write(lru_write), .lru_in(lru_in),
        .pmem_addr_sig(pmem_addr_sig), .out_data_sel(out_data_sel)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: arrays start as garbage so INIT has something to clear.
    logic [3:0]  m_valid = 4'hF;
    logic [3:0]  m_dirty = 4'hF;
    logic [2:0]  m_lru   = 3'b101;
    logic [11:0] m_tag [4] = '{12'hF00, 12'hF01, 12'hF02, 12'hF03};
    logic [11:0] req_tag = 12'h000;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (valid_write[i]) m_valid[i] <= valid_in;
            if (dirty_write[i]) m_dirty[i] <= dirty_in;
            if (tag_write[i])   m_tag[i]   <= req_tag;
        end
        if (lru_write) m_lru <= lru_in;
    end

    logic [1:0] victim, first_inv, first_cln, first_dty;
    logic       found_inv;

    always_comb begin
        hit       = 1'b0;
        cline_and = 2'd0;
        found_inv = 1'b0;
        first_inv = 2'd0;
        first_cln = 2'd0;
        first_dty = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m_valid[i] && m_tag[i] == req_tag) begin
                hit       = 1'b1;
                cline_and = 2'(i);
            end
            if (!m_valid[i]) begin
                found_inv = 1'b1;
                first_inv = 2'(i);
            end
            if (!m_dirty[i]) first_cln = 2'(i);
            if (m_dirty[i])  first_dty = 2'(i);
        end
        victim  = m_lru[2] ? (m_lru[0] ? 2'd3 : 2'd2) : (m_lru[1] ? 2'd1 : 2'd0);
        ow_line = found_inv ? first_inv : (!m_dirty[victim] ? victim : first_cln);
        line    = m_dirty[victim] ? victim : first_dty;
    end

    assign valid_out = m_valid;
    assign dirty_out = m_dirty;
    assign lru_out   = m_lru;

    // Response scoreboard: expected cycle and out_data_sel of each mem_resp.
    typedef struct {
        int    at;
        logic  sel;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    function automatic void expect_resp(input int at, input logic sel, input string name);
        exp_t e;
        e.at   = at;
        e.sel  = sel;
        e.name = name;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: mem_resp=1 at cycle %0d, none expected", cyc);
            end else begin
                got = sb.pop_front();
                if (cyc !== got.at || out_data_sel !== got.sel) begin
                    errors++;
                    $display("FAIL %s: resp cycle %0d sel %b, expected cycle %0d sel %b",
                             got.name, cyc, out_data_sel, got.at, got.sel);
                end
            end
        end
    end

    typedef struct {
        int         pw;
        int         pr;
        logic [3:0] wb_dw;
        logic       wb_di;
        logic       side;
    } txn_t;

    // Holds the request(s) until mem_resp and plays pmem with a fixed latency.
    // Entered and left just after a rising edge.
    task automatic transact(input bit wr, input bit rd, input logic [11:0] tag, input int lat,
                            input int budget, input string name, output txn_t r);
        bit wp, rp;
        int pcnt, n;
        wp = wr; rp = rd; pcnt = 0; n = 0;
        r.pw = 0; r.pr = 0; r.wb_dw = '0; r.wb_di = 1'b0; r.side = 1'b0;
        req_tag   = tag;
        mem_write = wp;
        mem_read  = rp;
        while ((wp || rp) && n < budget) begin
            #1;
            if (pmem_write === 1'b1 || pmem_read === 1'b1) begin
                pcnt++;
                if (pcnt == lat) pmem_resp = 1'b1;
            end
            #1;
            if (pmem_write === 1'b1 || pmem_read === 1'b1) begin
                checks++;
                if (pmem_write === 1'b1 && pmem_read === 1'b1) begin
                    errors++;
                    $display("FAIL %s_pmem_excl: read and write both 1, expected one", name);
                end else if (pmem_write === 1'b1) begin
                    r.pw++;
                    if (pmem_addr_sig !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_wb_addr: pmem_addr_sig %b, expected 1", name, pmem_addr_sig);
                    end
                    if (pmem_resp) begin
                        r.wb_dw = dirty_write;
                        r.wb_di = dirty_in;
                    end
                end else begin
                    r.pr++;
                    if (pmem_addr_sig !== 1'b0 || out_data_sel !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_rd_sel: addr_sig %b sel %b, expected 0 1", name, pmem_addr_sig, out_data_sel);
                    end
                    r.side = r.side | (|{valid_write, dirty_write, tag_write, data_write, lru_write});
                end
            end
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                if (wp) wp = 1'b0;
                else    rp = 1'b0;
            end
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pcnt = 0;
            end
            mem_write = wp;
            mem_read  = rp;
            n++;
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        checks++;
        if (wp || rp) begin
            errors++;
            $display("FAIL %s_timeout: no response within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic check_arrays(input string name, input logic [3:0] v, input logic [3:0] d, input logic [2:0] l);
        checks++;
        if (m_valid !== v || m_dirty !== d || m_lru !== l) begin
            errors++;
            $display("FAIL %s: valid %b dirty %b lru %b, expected %b %b %b", name, m_valid, m_dirty, m_lru, v, d, l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: resp %b pr %b pw %b, expected 0 0 0", mem_resp, pmem_read, pmem_write);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_write !== 4'hF || dirty_write !== 4'hF || valid_in !== 1'b0 || dirty_in !== 1'b0
            || lru_write !== 1'b1 || lru_in !== 3'b000 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL init_outputs: vw %h dw %h vi %b di %b lw %b li %b resp %b, expected f f 0 0 1 000 0",
                     valid_write, dirty_write, valid_in, dirty_in, lru_write, lru_in, mem_resp);
        end
        @(posedge clk); #1;
        check_arrays("init_cleared", 4'h0, 4'h0, 3'b000);
    endtask

    task automatic test_write_read();
        txn_t r;
        expect_resp(cyc, 1'b0, "wr_123");
        transact(1'b1, 1'b0, 12'h123, 1, 10, "wr_123", r);
        check_arrays("wr_123_state", 4'b0001, 4'b0001, 3'b110);
        expect_resp(cyc, 1'b0, "rd_123_hit");
        transact(1'b0, 1'b1, 12'h123, 1, 10, "rd_123", r);
        check_arrays("rd_123_state", 4'b0001, 4'b0001, 3'b110);
    endtask

    task automatic test_fill_and_wb();
        txn_t r;
        logic [2:0] lru_exp [3] = '{3'b100, 3'b001, 3'b000};
        logic [3:0] vd_exp  [3] = '{4'b0011, 4'b0111, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            expect_resp(cyc, 1'b0, "fill_wr");
            transact(1'b1, 1'b0, 12'h200 + 12'(k), 1, 10, "fill", r);
            check_arrays("fill_state", vd_exp[k], vd_exp[k], lru_exp[k]);
        end
        expect_resp(cyc + 6, 1'b0, "wb_then_wr_300");
        transact(1'b1, 1'b0, 12'h300, 5, 20, "wb_300", r);
        checks++;
        if (r.pw !== 5 || r.wb_dw !== 4'b0001 || r.wb_di !== 1'b0) begin
            errors++;
            $display("FAIL wb_sequence: pmem_write cycles %0d dirty_write %b dirty_in %b, expected 5 0001 0",
                     r.pw, r.wb_dw, r.wb_di);
        end
        checks++;
        if (m_tag[0] !== 12'h300) begin
            errors++;
            $display("FAIL wb_refill_tag: line0 tag %h, expected 300", m_tag[0]);
        end
        check_arrays("wb_state", 4'hF, 4'hF, 3'b110);
    endtask

    task automatic test_read_miss();
        txn_t r;
        expect_resp(cyc + 3, 1'b1, "rd_miss_777");
        transact(1'b0, 1'b1, 12'h777, 3, 20, "rd_miss", r);
        checks++;
        if (r.pr !== 3 || r.pw !== 0 || r.side !== 1'b0) begin
            errors++;
            $display("FAIL rd_miss_seq: pmem_read cycles %0d pmem_write cycles %0d array writes %b, expected 3 0 0",
                     r.pr, r.pw, r.side);
        end
        check_arrays("rd_miss_state", 4'hF, 4'hF, 3'b110);
    endtask

    task automatic test_back_to_back();
        txn_t r;
        expect_resp(cyc, 1'b0, "b2b_write");
        expect_resp(cyc + 1, 1'b0, "b2b_read");
        transact(1'b1, 1'b1, 12'h200, 1, 10, "b2b", r);
        check_arrays("b2b_state", 4'hF, 4'hF, 3'b100);
    endtask

    task automatic test_rst_mid_wb();
        req_tag   = 12'h400;
        mem_write = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_wb_active: pmem_write %b, expected 1", pmem_write);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mem_write = 1'b0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL mid_wb_drop: pmem_write %b pmem_read %b in rst cycle, expected 0 0", pmem_write, pmem_read);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_write !== 4'hF || pmem_write !== 1'b0 || lru_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_wb_init: vw %h pw %b lw %b, expected f 0 1", valid_write, pmem_write, lru_write);
        end
        @(posedge clk); #1;
        check_arrays("mid_wb_cleared", 4'h0, 4'h0, 3'b000);
    endtask

`ifdef EWB_IDLE_DRAIN_EN
    task automatic test_idle_drain();
        txn_t r;
        int   idle;
        bit   seen;
        expect_resp(cyc, 1'b0, "drain_setup");
        transact(1'b1, 1'b0, 12'h050, 1, 10, "drain_setup", r);
        idle = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (pmem_write === 1'b1) begin
                seen = 1'b1;
            end else begin
                idle++;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen || idle !== 8) begin
            errors++;
            $display("FAIL drain_start: seen %b after %0d idle cycles, expected 1 after 8", seen, idle);
        end
        expect_resp(cyc + 4, 1'b0, "drain_wait_rd");
        transact(1'b0, 1'b1, 12'h050, 4, 20, "drain", r);
        checks++;
        if (r.pw !== 4 || r.wb_dw !== 4'b0001 || r.wb_di !== 1'b0) begin
            errors++;
            $display("FAIL drain_wb: pmem_write cycles %0d dirty_write %b dirty_in %b, expected 4 0001 0",
                     r.pw, r.wb_dw, r.wb_di);
        end
        checks++;
        if (m_dirty !== 4'b0000 || m_valid !== 4'b0001) begin
            errors++;
            $display("FAIL drain_state: valid %b dirty %b, expected 0001 0000", m_valid, m_dirty);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_fill_and_wb();
        test_read_miss();
        test_back_to_back();
        test_rst_mid_wb();
`ifdef EWB_IDLE_DRAIN_EN
        test_idle_drain();
`endif
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_resp: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
